// File: rtl/seven_segment_scanner.sv
// Time-multiplexed driver for a 4-digit seven-segment display. Each digit slot
// opens with an all-dark interval, and new data is shown only from a frame boundary.
module seven_segment_scanner #(
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic [3:0]  blank,
  input  logic [3:0]  dp,
  input  logic        load,
  output logic [4:0]  number,
  output logic [3:0]  anode,
  output logic        dp_n,
  output logic        pending,
  output logic        frame_done
);

  localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [4:0]    NUM_DARK   = 5'h10;

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic [1:0]    digit;
  logic          slot_end, frame_end;

  logic [15:0] disp_value, pend_value;
  logic [3:0]  disp_blank, pend_blank;
  logic [3:0]  disp_dp, pend_dp;
  // Set by the first commit: the display stays fully dark until data has been shown.
  logic        shown;

  logic [3:0] anode_d;
  logic [4:0] number_d;
  logic       dp_n_d;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (digit == 2'd3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_BLANK;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    anode_d    = 4'b1111;
    number_d   = NUM_DARK;
    dp_n_d     = 1'b1;
    case (state)
      ST_BLANK: if (cnt == BLANK_LAST) state_next = ST_SHOW;
      ST_SHOW: begin
        if (slot_end) state_next = ST_BLANK;
        anode_d  = shown ? ~(4'b0001 << digit) : 4'b1111;
        number_d = disp_blank[digit] ? NUM_DARK : {1'b0, disp_value[digit*4 +: 4]};
        dp_n_d   = ~disp_dp[digit];
      end
      default: state_next = ST_BLANK;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      digit      <= 2'd0;
      disp_value <= 16'h0000;
      disp_blank <= 4'hF;
      disp_dp    <= 4'h0;
      pend_value <= 16'h0000;
      pend_blank <= 4'h0;
      pend_dp    <= 4'h0;
      pending    <= 1'b0;
      shown      <= 1'b0;
      anode      <= 4'b1111;
      number     <= NUM_DARK;
      dp_n       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      anode      <= anode_d;
      number     <= number_d;
      dp_n       <= dp_n_d;
      frame_done <= frame_end;

      if (slot_end) begin
        cnt   <= '0;
        digit <= digit + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      // Commit reads the pending set held before this edge; a same-cycle load refills it.
      if (frame_end && pending) begin
        disp_value <= pend_value;
        disp_blank <= pend_blank;
        disp_dp    <= pend_dp;
        shown      <= 1'b1;
      end

      if (load) begin
        pend_value <= value;
        pend_blank <= blank;
        pend_dp    <= dp;
        pending    <= 1'b1;
      end else if (frame_end) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed bench for seven_segment_scanner with 8-cycle slots and 2-cycle blanking.
module tb_seven_segment_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value;
  logic [3:0]  blank;
  logic [3:0]  dp;
  logic        load;
  logic [4:0]  number;
  logic [3:0]  anode;
  logic        dp_n;
  logic        pending;
  logic        frame_done;

  int tests = 0;
  int failed = 0;

  seven_segment_scanner #(.DIGIT_CYCLES(8), .BLANK_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .value(value), .blank(blank), .dp(dp), .load(load),
    .number(number), .anode(anode), .dp_n(dp_n), .pending(pending), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // k = cycles since the last frame_done sample; k=1..32 covers one whole frame.
  function automatic logic [3:0] exp_anode(int k, logic lit);
    int d = (k - 1) / 8;
    int c = (k - 1) % 8;
    if (c < 2 || !lit) return 4'b1111;
    return ~(4'b0001 << d);
  endfunction

  function automatic logic [4:0] exp_number(int k, logic [15:0] v, logic [3:0] b);
    int d = (k - 1) / 8;
    int c = (k - 1) % 8;
    if (c < 2 || b[d]) return 5'h10;
    return {1'b0, v[d*4 +: 4]};
  endfunction

  function automatic logic exp_dpn(int k, logic [3:0] p);
    int d = (k - 1) / 8;
    int c = (k - 1) % 8;
    if (c < 2) return 1'b1;
    return ~p[d];
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] b, input logic [3:0] p);
    value = v; blank = b; dp = p; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic wait_frame(output int n);
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (frame_done === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 1'b0; value = '0; blank = '0; dp = '0;
    #2;
    tests++;
    if (anode !== 4'b1111 || number !== 5'h10 || dp_n !== 1'b1 || pending !== 1'b0 || frame_done !== 1'b0) begin
      failed++;
      $display("FAIL reset_state anode=%b number=%h dp_n=%b pending=%b frame_done=%b expected 1111/10/1/0/0",
               anode, number, dp_n, pending, frame_done);
    end
    step(); step();
    reset = 1'b0;
  endtask

  task automatic test_idle();
    for (int f = 0; f < 2; f++) begin
      for (int k = 1; k <= 32; k++) begin
        step();
        tests++;
        if (anode !== 4'b1111 || number !== 5'h10 || dp_n !== 1'b1 || frame_done !== (k == 32)) begin
          failed++;
          $display("FAIL idle f=%0d k=%0d anode=%b number=%h dp_n=%b fd=%b expected 1111/10/1/%b",
                   f, k, anode, number, dp_n, frame_done, (k == 32));
        end
      end
    end
  endtask

  task automatic test_load_show();
    int n;
    do_load(16'h12AF, 4'b0000, 4'b0100);
    tests++;
    if (pending !== 1'b1) begin failed++; $display("FAIL load_pending got %b expected 1", pending); end
    wait_frame(n);
    tests++;
    if (n != 31) begin failed++; $display("FAIL load_wait cycles %0d expected 31", n); end
    tests++;
    if (pending !== 1'b0) begin failed++; $display("FAIL load_commit pending %b expected 0", pending); end
    for (int k = 1; k <= 32; k++) begin
      step();
      tests++;
      if (anode !== exp_anode(k, 1'b1) || number !== exp_number(k, 16'h12AF, 4'b0000) ||
          dp_n !== exp_dpn(k, 4'b0100) || frame_done !== (k == 32)) begin
        failed++;
        $display("FAIL show_12AF k=%0d anode=%b/%b number=%h/%h dp_n=%b/%b fd=%b",
                 k, anode, exp_anode(k, 1'b1), number, exp_number(k, 16'h12AF, 4'b0000),
                 dp_n, exp_dpn(k, 4'b0100), frame_done);
      end
    end
  endtask

  task automatic test_last_load_wins();
    int n;
    do_load(16'h1111, 4'b0000, 4'b0000);
    step(); step(); step();
    do_load(16'h2222, 4'b0000, 4'b0000);
    tests++;
    if (pending !== 1'b1) begin failed++; $display("FAIL overwrite_pending got %b expected 1", pending); end
    wait_frame(n);
    tests++;
    if (n != 27) begin failed++; $display("FAIL overwrite_wait cycles %0d expected 27", n); end
    tests++;
    if (pending !== 1'b0) begin failed++; $display("FAIL overwrite_commit pending %b expected 0", pending); end
    for (int k = 1; k <= 32; k++) begin
      step();
      tests++;
      if (anode !== exp_anode(k, 1'b1) || number !== exp_number(k, 16'h2222, 4'b0000) ||
          dp_n !== exp_dpn(k, 4'b0000) || frame_done !== (k == 32)) begin
        failed++;
        $display("FAIL show_2222 k=%0d anode=%b/%b number=%h/%h dp_n=%b fd=%b",
                 k, anode, exp_anode(k, 1'b1), number, exp_number(k, 16'h2222, 4'b0000), dp_n, frame_done);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_load(16'h4444, 4'b0000, 4'b0000);
    for (int i = 0; i < 30; i++) step();
    do_load(16'h3333, 4'b0000, 4'b0001);
    tests++;
    if (frame_done !== 1'b1 || pending !== 1'b1) begin
      failed++;
      $display("FAIL boundary_load fd=%b pending=%b expected 1/1", frame_done, pending);
    end
    for (int k = 1; k <= 32; k++) begin
      step();
      tests++;
      if (anode !== exp_anode(k, 1'b1) || number !== exp_number(k, 16'h4444, 4'b0000) ||
          dp_n !== exp_dpn(k, 4'b0000) || frame_done !== (k == 32) || (k < 32 && pending !== 1'b1)) begin
        failed++;
        $display("FAIL show_4444 k=%0d anode=%b/%b number=%h/%h dp_n=%b fd=%b pending=%b",
                 k, anode, exp_anode(k, 1'b1), number, exp_number(k, 16'h4444, 4'b0000), dp_n, frame_done, pending);
      end
    end
    tests++;
    if (pending !== 1'b0) begin failed++; $display("FAIL boundary_commit pending %b expected 0", pending); end
    for (int k = 1; k <= 32; k++) begin
      step();
      tests++;
      if (anode !== exp_anode(k, 1'b1) || number !== exp_number(k, 16'h3333, 4'b0000) ||
          dp_n !== exp_dpn(k, 4'b0001) || frame_done !== (k == 32)) begin
        failed++;
        $display("FAIL show_3333 k=%0d anode=%b/%b number=%h/%h dp_n=%b/%b fd=%b",
                 k, anode, exp_anode(k, 1'b1), number, exp_number(k, 16'h3333, 4'b0000),
                 dp_n, exp_dpn(k, 4'b0001), frame_done);
      end
    end
  endtask

  task automatic test_blank_digit();
    int n;
    do_load(16'h5678, 4'b1000, 4'b1000);
    wait_frame(n);
    tests++;
    if (n != 31) begin failed++; $display("FAIL blank_wait cycles %0d expected 31", n); end
    for (int k = 1; k <= 32; k++) begin
      step();
      tests++;
      if (anode !== exp_anode(k, 1'b1) || number !== exp_number(k, 16'h5678, 4'b1000) ||
          dp_n !== exp_dpn(k, 4'b1000) || frame_done !== (k == 32)) begin
        failed++;
        $display("FAIL show_blank k=%0d anode=%b/%b number=%h/%h dp_n=%b/%b fd=%b",
                 k, anode, exp_anode(k, 1'b1), number, exp_number(k, 16'h5678, 4'b1000),
                 dp_n, exp_dpn(k, 4'b1000), frame_done);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    do_load(16'h9999, 4'b0000, 4'b0000);
    for (int i = 0; i < 19; i++) step();
    tests++;
    if (anode !== 4'b1011 || number !== 5'h06) begin
      failed++;
      $display("FAIL pre_reset anode=%b number=%h expected 1011/06", anode, number);
    end
    #2 reset = 1'b1;
    #1;
    tests++;
    if (anode !== 4'b1111 || number !== 5'h10 || dp_n !== 1'b1 || pending !== 1'b0 || frame_done !== 1'b0) begin
      failed++;
      $display("FAIL async_reset anode=%b number=%h dp_n=%b pending=%b fd=%b expected 1111/10/1/0/0",
               anode, number, dp_n, pending, frame_done);
    end
    @(negedge clk);
    step();
    reset = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      step();
      tests++;
      if (anode !== 4'b1111 || number !== 5'h10 || dp_n !== 1'b1 || pending !== 1'b0 || frame_done !== (k == 32)) begin
        failed++;
        $display("FAIL post_reset k=%0d anode=%b number=%h dp_n=%b pending=%b fd=%b",
                 k, anode, number, dp_n, pending, frame_done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_load_show();
    test_last_load_wins();
    test_back_to_back();
    test_blank_digit();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
